// File: rtl/alu_ctrl_pkg.sv
// Shared constants for the ALU control issue block:
// ALU control codes, ALUOp classes, funct fields and FSM states.
package alu_ctrl_pkg;

  localparam logic [3:0] CTRL_ADD = 4'b0010;
  localparam logic [3:0] CTRL_SUB = 4'b0110;
  localparam logic [3:0] CTRL_AND = 4'b0000;
  localparam logic [3:0] CTRL_OR  = 4'b0001;
  localparam logic [3:0] CTRL_MUL = 4'b1111;

  localparam logic [1:0] ALUOP_ADD = 2'b00;
  localparam logic [1:0] ALUOP_SUB = 2'b01;
  localparam logic [1:0] ALUOP_R   = 2'b10;
  localparam logic [1:0] ALUOP_I   = 2'b11;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;
  localparam logic [6:0] F7_MUL  = 7'b0000001;

  localparam logic [2:0] F3_ADD = 3'b000;
  localparam logic [2:0] F3_AND = 3'b111;
  localparam logic [2:0] F3_OR  = 3'b110;

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_HOLD     = 2'd1;
  localparam logic [1:0] ST_MUL_WAIT = 2'd2;

endpackage

// File: rtl/alu_ctrl_decode.sv
// Combinational ALUOp/funct decode to {code, illegal, is_mul}.
// Multiply decodes only when ALU_CTRL_MUL_EN is defined.
module alu_ctrl_decode
  import alu_ctrl_pkg::*;
(
  input  logic [1:0] alu_op_i,
  input  logic [6:0] funct7_i,
  input  logic [2:0] funct3_i,
  output logic [3:0] code_o,
  output logic       illegal_o,
  output logic       is_mul_o
);

  // Map the instruction class and funct fields to an ALU code
  always_comb begin
    code_o    = CTRL_ADD;
    illegal_o = 1'b0;
    is_mul_o  = 1'b0;
    unique case (alu_op_i)
      ALUOP_ADD: code_o = CTRL_ADD;
      ALUOP_SUB: code_o = CTRL_SUB;
      ALUOP_R: begin
        if (funct7_i == F7_BASE && funct3_i == F3_ADD)
          code_o = CTRL_ADD;
        else if (funct7_i == F7_BASE && funct3_i == F3_AND)
          code_o = CTRL_AND;
        else if (funct7_i == F7_BASE && funct3_i == F3_OR)
          code_o = CTRL_OR;
        else if (funct7_i == F7_ALT && funct3_i == F3_ADD)
          code_o = CTRL_SUB;
`ifdef ALU_CTRL_MUL_EN
        else if (funct7_i == F7_MUL && funct3_i == F3_ADD) begin
          code_o   = CTRL_MUL;
          is_mul_o = 1'b1;
        end
`endif
        else
          illegal_o = 1'b1;
      end
      ALUOP_I: begin
        unique case (funct3_i)
          F3_ADD:  code_o = CTRL_ADD;
          F3_AND:  code_o = CTRL_AND;
          F3_OR:   code_o = CTRL_OR;
          default: illegal_o = 1'b1;
        endcase
      end
      default: illegal_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_ctrl_issue.sv
// ALU control issue: decode, ID/EX-style hold register, handshake.
// ALU_CTRL_MUL_EN adds the multi-cycle multiply wait path.
module alu_ctrl_issue
  import alu_ctrl_pkg::*;
#(
  parameter int MUL_LAT = 3
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       valid_i,
  output logic       ready_o,
  input  logic [1:0] ALUOp_i,
  input  logic [6:0] funct7_i,
  input  logic [2:0] funct3_i,
  input  logic       flush_i,
  output logic [3:0] ALUCtrl_o,
  output logic       illegal_o,
  output logic       valid_o,
  input  logic       ready_i
);

  logic [1:0] state_q, state_d;
  logic [3:0] ctrl_q, ctrl_d;
  logic       ill_q, ill_d;
  logic [3:0] dec_code;
  logic       dec_ill;
  logic       dec_mul;
  logic       accept;

`ifdef ALU_CTRL_MUL_EN
  localparam int CW = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;
  logic [CW-1:0] cnt_q, cnt_d;
`else
  logic unused_cfg;
  assign unused_cfg = dec_mul | (MUL_LAT == 0);
`endif

  alu_ctrl_decode u_dec (
    .alu_op_i  (ALUOp_i),
    .funct7_i  (funct7_i),
    .funct3_i  (funct3_i),
    .code_o    (dec_code),
    .illegal_o (dec_ill),
    .is_mul_o  (dec_mul)
  );

  assign valid_o   = (state_q == ST_HOLD);
  assign ready_o   = (state_q == ST_IDLE) ||
                     ((state_q == ST_HOLD) && ready_i);
  assign accept    = valid_i && ready_o;
  assign ALUCtrl_o = ctrl_q;
  assign illegal_o = ill_q;

  // Next state: drain, multiply countdown, accept, then flush override
  always_comb begin
    state_d = state_q;
    ctrl_d  = ctrl_q;
    ill_d   = ill_q;
`ifdef ALU_CTRL_MUL_EN
    cnt_d   = cnt_q;
`endif
    if (state_q == ST_HOLD && ready_i)
      state_d = ST_IDLE;
`ifdef ALU_CTRL_MUL_EN
    if (state_q == ST_MUL_WAIT) begin
      cnt_d = cnt_q - CW'(1);
      if (cnt_q == CW'(1))
        state_d = ST_HOLD;
    end
`endif
    if (accept) begin
      ctrl_d  = dec_code;
      ill_d   = dec_ill;
      state_d = ST_HOLD;
`ifdef ALU_CTRL_MUL_EN
      if (dec_mul && MUL_LAT > 1) begin
        state_d = ST_MUL_WAIT;
        cnt_d   = CW'(MUL_LAT - 1);
      end
`endif
    end
    if (flush_i) begin
      state_d = ST_IDLE;
      ctrl_d  = ctrl_q;
      ill_d   = ill_q;
`ifdef ALU_CTRL_MUL_EN
      cnt_d   = '0;
`endif
    end
  end

  // State and output register, synchronous reset
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      ctrl_q  <= CTRL_ADD;
      ill_q   <= 1'b0;
`ifdef ALU_CTRL_MUL_EN
      cnt_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      ctrl_q  <= ctrl_d;
      ill_q   <= ill_d;
`ifdef ALU_CTRL_MUL_EN
      cnt_q   <= cnt_d;
`endif
    end
  end

endmodule

// File: tb/tb_alu_ctrl_issue.sv
// Scoreboard bench for alu_ctrl_issue: driver pushes expectations,
// a negedge monitor checks valid/ready/code against the queue.
module tb_alu_ctrl_issue;

  localparam int MUL_LAT = 3;
`ifdef ALU_CTRL_MUL_EN
  localparam bit MUL_EN = 1'b1;
`else
  localparam bit MUL_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_i = 1'b1;
  logic       valid_i = 1'b0;
  logic       ready_o;
  logic [1:0] alu_op = 2'b00;
  logic [6:0] f7 = 7'd0;
  logic [2:0] f3 = 3'd0;
  logic       flush_i = 1'b0;
  logic [3:0] ALUCtrl_o;
  logic       illegal_o;
  logic       valid_o;
  logic       ready_i = 1'b1;

  typedef struct {
    logic [3:0] code;
    logic       ill;
    int         due;
  } exp_t;

  exp_t q[$];
  int   vectors = 0;
  int   miscompares = 0;
  int   cyc = 0;
  bit   chk_en = 1'b0;
  bit   rand_mode = 1'b0;

  alu_ctrl_issue #(.MUL_LAT(MUL_LAT)) dut (
    .clk_i     (clk),
    .rst_i     (rst_i),
    .valid_i   (valid_i),
    .ready_o   (ready_o),
    .ALUOp_i   (alu_op),
    .funct7_i  (f7),
    .funct3_i  (f3),
    .flush_i   (flush_i),
    .ALUCtrl_o (ALUCtrl_o),
    .illegal_o (illegal_o),
    .valid_o   (valid_o),
    .ready_i   (ready_i)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void check(string name, logic [31:0] act,
                                logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)",
               name, act, exp, cyc);
    end
  endfunction

  // Reference decode: {is_mul, illegal, code}
  function automatic logic [5:0] ref_dec(logic [1:0] op,
                                         logic [6:0] fn7,
                                         logic [2:0] fn3);
    logic [3:0] base;
    logic       base_ok;
    base_ok = 1'b1;
    if (fn3 == 3'b000)      base = 4'b0010;
    else if (fn3 == 3'b111) base = 4'b0000;
    else if (fn3 == 3'b110) base = 4'b0001;
    else begin base = 4'b0010; base_ok = 1'b0; end
    if (op == 2'b00) return {2'b00, 4'b0010};
    if (op == 2'b01) return {2'b00, 4'b0110};
    if (op == 2'b11 || fn7 == 7'h00)
      return {1'b0, !base_ok, base};
    if (fn7 == 7'h20 && fn3 == 3'b000) return {2'b00, 4'b0110};
    if (fn7 == 7'h01 && fn3 == 3'b000 && MUL_EN)
      return {2'b10, 4'b1111};
    return {2'b01, 4'b0010};
  endfunction

  // Monitor: compare visible outputs against the pending queue
  initial forever begin
    bit exp_v;
    @(negedge clk);
    if (rst_i) begin
      q.delete();
    end else if (chk_en) begin
      exp_v = (q.size() > 0) && (cyc >= q[0].due);
      check("valid_o", valid_o, exp_v);
      check("ready_o", ready_o,
            (q.size() == 0) || (exp_v && ready_i));
      if (exp_v) begin
        check("ALUCtrl_o", ALUCtrl_o, q[0].code);
        check("illegal_o", illegal_o, q[0].ill);
      end
      if (flush_i) q.delete();
      else if (exp_v && ready_i) void'(q.pop_front());
    end
  end

  // Random downstream backpressure and flushes
  initial forever begin
    @(posedge clk);
    #1;
    if (rand_mode) begin
      ready_i = ($urandom_range(0, 3) != 0);
      flush_i = ($urandom_range(0, 19) == 0);
    end
  end

  task automatic send(input logic [1:0] op, input logic [6:0] fn7,
                      input logic [2:0] fn3);
    logic [5:0] r;
    bit         done;
    exp_t       e;
    r = ref_dec(op, fn7, fn3);
    alu_op = op;
    f7 = fn7;
    f3 = fn3;
    valid_i = 1'b1;
    done = 1'b0;
    for (int i = 0; i < 60 && !done; i++) begin
      @(negedge clk);
      #1;
      if (ready_o) begin
        done = 1'b1;
        if (!flush_i) begin
          e.code = r[3:0];
          e.ill  = r[4];
          e.due  = cyc + ((r[5] && MUL_EN) ? MUL_LAT : 1);
          q.push_back(e);
        end
      end
    end
    if (!done) begin
      vectors++;
      miscompares++;
      $display("FAIL accept_timeout: ready_o never seen, op %0h", op);
    end
    @(posedge clk);
    #1;
    valid_i = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [6:0] rf7;
    logic [2:0] rf3;
    int         g;
    repeat (3) @(posedge clk);
    #1;
    rst_i = 1'b0;
    chk_en = 1'b1;
    @(negedge clk);
    check("reset_code", ALUCtrl_o, 4'b0010);
    check("reset_illegal", illegal_o, 1'b0);
    check("reset_valid", valid_o, 1'b0);
    check("reset_ready", ready_o, 1'b1);
    @(posedge clk);
    #1;

    send(2'b10, 7'h20, 3'b000);
    repeat (2) @(posedge clk);
    #1;

    send(2'b10, 7'h00, 3'b000);
    send(2'b10, 7'h00, 3'b111);
    send(2'b11, 7'h55, 3'b110);
    repeat (2) @(posedge clk);
    #1;

    send(2'b10, 7'h01, 3'b000);
    check("mul_code_at_accept", ALUCtrl_o,
          MUL_EN ? 4'b1111 : 4'b0010);
    repeat (MUL_LAT + 1) @(posedge clk);
    #1;

    ready_i = 1'b0;
    send(2'b00, 7'h00, 3'b000);
    fork
      send(2'b10, 7'h00, 3'b111);
      begin
        repeat (4) @(posedge clk);
        #1;
        ready_i = 1'b1;
      end
    join
    repeat (2) @(posedge clk);
    #1;

    send(2'b10, 7'h01, 3'b000);
    flush_i = 1'b1;
    valid_i = 1'b1;
    alu_op = 2'b00;
    @(posedge clk);
    #1;
    flush_i = 1'b0;
    valid_i = 1'b0;
    @(negedge clk);
    check("flush_valid", valid_o, 1'b0);
    check("flush_ready", ready_o, 1'b1);
    @(posedge clk);
    #1;

    send(2'b10, 7'h7f, 3'b000);
    repeat (2) @(posedge clk);
    #1;

    ready_i = 1'b0;
    send(2'b11, 7'h00, 3'b111);
    rst_i = 1'b1;
    @(posedge clk);
    #1;
    rst_i = 1'b0;
    ready_i = 1'b1;
    @(negedge clk);
    check("rst_hold_valid", valid_o, 1'b0);
    check("rst_hold_code", ALUCtrl_o, 4'b0010);
    check("rst_hold_illegal", illegal_o, 1'b0);
    @(posedge clk);
    #1;

    rand_mode = 1'b1;
    for (int n = 0; n < 300; n++) begin
      g = $urandom_range(0, 2);
      if (g != 0) begin
        repeat (g) @(posedge clk);
        #1;
      end
      case ($urandom_range(0, 3))
        0: rf7 = 7'h00;
        1: rf7 = 7'h20;
        2: rf7 = 7'h01;
        default: rf7 = 7'($urandom);
      endcase
      case ($urandom_range(0, 3))
        0: rf3 = 3'b000;
        1: rf3 = 3'b111;
        2: rf3 = 3'b110;
        default: rf3 = 3'($urandom);
      endcase
      send(2'($urandom_range(0, 3)), rf7, rf3);
    end
    rand_mode = 1'b0;
    @(posedge clk);
    #2;
    flush_i = 1'b0;
    ready_i = 1'b1;
    repeat (MUL_LAT + 4) @(posedge clk);
    @(negedge clk);
    #1;
    check("drain_queue_empty", q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
